// File: rtl/graph_loader.sv
// Loads the byte-serial Bellman-Ford problem image (N, src, N x N weights) into graph SRAM, 16 weights per word.
// Optional feature: define LOADER_CHECKSUM_EN to enable the 16-bit weight checksum on loadChecksum.
module graph_loader #(
  parameter int MAX_NODES = 32,
  parameter int IN_AW     = 10,
  parameter int G_AW      = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       inputSRAM_Data,
  output logic [IN_AW-1:0] inputSRAM_Addr,
  output logic [G_AW-1:0]  graphWrite_Addr,
  output logic [127:0]     graphWrite_Data,
  output logic             graph_WE,
  output logic [7:0]       numNodes,
  output logic [7:0]       srcNode,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      loadChecksum
);

  localparam int          WPR       = (MAX_NODES + 15) / 16;
  localparam logic [8:0]  MAX_N     = 9'(MAX_NODES);
  localparam logic [16:0] IMG_SPACE = 17'(2 ** IN_AW);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CHK, S_LOAD, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic               hdr_second_q, hdr_second_d;
  logic [IN_AW-1:0]   addr_q, addr_d;
  logic               rd_vld_q, rd_vld_d;
  logic [7:0]         row_q, row_d;
  logic [7:0]         col_q, col_d;
  logic [127:0]       pack_q, pack_d;
  logic               we_q, we_d;
  logic [G_AW-1:0]    waddr_q, waddr_d;
  logic [7:0]         n_q, n_d;
  logic [7:0]         src_q, src_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               accept;
  logic [15:0]        nn;
  logic [IN_AW-1:0]   last_addr;
  logic               hdr_bad;
  logic [3:0]         lane;
  logic               row_end;

  // Header checks work on the registered N/src so the N*N product starts from flops.
  always_comb begin
    accept    = (state_q == S_IDLE) && start;
    nn        = 16'(n_q) * 16'(n_q);
    last_addr = IN_AW'(nn + 16'd1);
    hdr_bad   = (n_q == 8'd0) || ({1'b0, n_q} > MAX_N) || (src_q >= n_q) ||
                (({1'b0, nn} + 17'd2) > IMG_SPACE);
    lane      = col_q[3:0];
    row_end   = (col_q == (n_q - 8'd1));
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d      = state_q;
    hdr_second_d = hdr_second_q;
    addr_d       = addr_q;
    rd_vld_d     = 1'b0;
    row_d        = row_q;
    col_d        = col_q;
    pack_d       = pack_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    n_d          = n_q;
    src_d        = src_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;

    // Byte on the bus belongs to (row_q, col_q); lane 0 starts a fresh word with unfilled lanes zero.
    if (rd_vld_q) begin
      if (lane == 4'd0) pack_d = '0;
      pack_d[{lane, 3'b000} +: 8] = inputSRAM_Data;
      if ((lane == 4'hF) || row_end) begin
        we_d    = 1'b1;
        waddr_d = G_AW'(row_q) * G_AW'(WPR) + G_AW'(col_q[7:4]);
      end
      if (row_end) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d      = S_HDR;
          addr_d       = IN_AW'(1);
          busy_d       = 1'b1;
          error_d      = 1'b0;
          hdr_second_d = 1'b0;
          row_d        = '0;
          col_d        = '0;
        end
      end
      S_HDR: begin
        if (!hdr_second_q) begin
          n_d          = inputSRAM_Data;
          hdr_second_d = 1'b1;
          addr_d       = addr_q + IN_AW'(1);
        end else begin
          src_d   = inputSRAM_Data;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (hdr_bad) begin
          state_d = S_ERR;
          addr_d  = '0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rd_vld_d = 1'b1;
        if (addr_q == last_addr) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + IN_AW'(1);
        end
      end
      S_DRAIN: begin
        // Last byte has been packed and its word is on the write port this cycle.
        if (!rd_vld_q && we_q) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done_d  = 1'b1;
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only; the pack buffer is an ordinary register and is reset with the rest.
    if (!reset) begin
      state_q      <= S_IDLE;
      hdr_second_q <= 1'b0;
      addr_q       <= '0;
      rd_vld_q     <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      pack_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      n_q          <= '0;
      src_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_second_q <= hdr_second_d;
      addr_q       <= addr_d;
      rd_vld_q     <= rd_vld_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pack_q       <= pack_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      n_q          <= n_d;
      src_q        <= src_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept)        csum_d = '0;
    else if (rd_vld_q) csum_d = csum_q + 16'(inputSRAM_Data);
  end

  always_ff @(posedge clock) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign loadChecksum = csum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign loadChecksum  = 16'h0000;
`endif

  assign inputSRAM_Addr  = addr_q;
  assign graphWrite_Addr = waddr_q;
  assign graphWrite_Data = pack_q;
  assign graph_WE        = we_q;
  assign numNodes        = n_q;
  assign srcNode         = src_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_graph_loader.sv
// Directed bench for graph_loader: byte-wide input SRAM model, write log of the graph port, per-scenario checks.
module tb_graph_loader;

  localparam int LIMIT = 3000;

  logic         clock;
  logic         reset;
  logic         start;
  logic [7:0]   inputSRAM_Data;
  logic [9:0]   inputSRAM_Addr;
  logic [12:0]  graphWrite_Addr;
  logic [127:0] graphWrite_Data;
  logic         graph_WE;
  logic [7:0]   numNodes;
  logic [7:0]   srcNode;
  logic         busy;
  logic         done;
  logic         error;
  logic [15:0]  loadChecksum;

  logic [7:0]   mem [0:1023];
  logic [7:0]   sram_q;
  logic [186:0] all_outs;

  logic [12:0]  w_addr [$];
  logic [127:0] w_data [$];

  int checks = 0;
  int errors = 0;

  graph_loader dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .inputSRAM_Data  (inputSRAM_Data),
    .inputSRAM_Addr  (inputSRAM_Addr),
    .graphWrite_Addr (graphWrite_Addr),
    .graphWrite_Data (graphWrite_Data),
    .graph_WE        (graph_WE),
    .numNodes        (numNodes),
    .srcNode         (srcNode),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .loadChecksum    (loadChecksum)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous-read SRAM: address sampled at an edge, data valid during the following cycle.
  always @(posedge clock) sram_q <= mem[inputSRAM_Addr];
  assign inputSRAM_Data = sram_q;

  assign all_outs = {inputSRAM_Addr, graphWrite_Addr, graphWrite_Data, graph_WE, numNodes,
                     srcNode, busy, done, error, loadChecksum};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] wt(input int mode, input int n, input int r, input int c);
    case (mode)
      0:       return 8'(r * n + c + 1);
      1:       return 8'd1;
      default: return 8'((r * 7 + c * 13 + 5) % 256);
    endcase
  endfunction

  function automatic logic [15:0] exp_checksum(input int n, input int mode);
    logic [15:0] s = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) s = s + 16'(wt(mode, n, r, c));
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic load_image(input int n, input int src, input int mode);
    for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
    mem[0] = 8'(n);
    mem[1] = 8'(src);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (2 + r * n + c < 1024) mem[2 + r * n + c] = wt(mode, n, r, c);
  endtask

  // Pulse start, then sample every negedge: cyc == k means k edges after the accepting edge.
  task automatic run_image(input bit spam, output int lat, output int max_a, output int dones,
                           output logic busy0, output logic err0);
    int cyc;
    w_addr.delete();
    w_data.delete();
    lat   = -1;
    max_a = 0;
    dones = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    busy0 = busy;
    err0  = error;
    cyc   = 0;
    while ((cyc < LIMIT) && !((lat >= 0) && (cyc > lat + 3))) begin
      if (graph_WE) begin
        w_addr.push_back(graphWrite_Addr);
        w_data.push_back(graphWrite_Data);
      end
      if (int'(inputSRAM_Addr) > max_a) max_a = int'(inputSRAM_Addr);
      if (done) begin
        dones++;
        if (lat < 0) lat = cyc;
      end
      start = spam && (lat < 0) && (cyc % 2 == 1);
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_writes(input int n, input int mode, input string tag);
    int   chunks = (n + 15) / 16;
    int   k      = 0;
    bit   bad    = 0;
    logic [12:0]  exp_a;
    logic [127:0] exp_d;
    checks++;
    if (w_addr.size() != n * chunks) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, w_addr.size(), n * chunks);
    end
    checks++;
    for (int r = 0; r < n; r++) begin
      for (int ch = 0; ch < chunks; ch++) begin
        exp_a = 13'(r * 2 + ch);
        exp_d = '0;
        for (int j = 0; j < 16; j++)
          if (ch * 16 + j < n) exp_d[j*8 +: 8] = wt(mode, n, r, ch * 16 + j);
        if ((k < w_addr.size()) && !bad && ((w_addr[k] !== exp_a) || (w_data[k] !== exp_d))) begin
          bad = 1;
          $display("FAIL %s write_content[%0d]: got addr %0d data %h expected addr %0d data %h",
                   tag, k, w_addr[k], w_data[k], exp_a, exp_d);
        end
        k++;
      end
    end
    if (bad) errors++;
  endtask

  task automatic check_success(input string tag, input int n, input int src, input int mode,
                               input int lat, input int dones, input logic busy0);
    checks++;
    if (lat !== n * n + 6) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, n * n + 6);
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", tag, dones); end
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b expected 1", tag, busy0); end
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL %s error: got %b expected 0", tag, error); end
    checks++;
    if ((numNodes !== 8'(n)) || (srcNode !== 8'(src))) begin
      errors++;
      $display("FAIL %s header: got N=%0d src=%0d expected N=%0d src=%0d", tag, numNodes, srcNode, n, src);
    end
    checks++;
    if (loadChecksum !== exp_checksum(n, mode)) begin
      errors++;
      $display("FAIL %s checksum: got %0d expected %0d", tag, loadChecksum, exp_checksum(n, mode));
    end
    check_writes(n, mode, tag);
  endtask

  task automatic check_error_run(input string tag, input int lat, input int dones);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL %s err_latency: got %0d expected 4", tag, lat); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL %s err_done_pulses: got %0d expected 1", tag, dones); end
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL %s err_flag: got %b expected 1", tag, error); end
    checks++;
    if (w_addr.size() != 0) begin
      errors++;
      $display("FAIL %s err_writes: got %0d expected 0", tag, w_addr.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs); end
    start = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ((busy !== 1'b0) || (inputSRAM_Addr !== 10'd0)) begin
      errors++;
      $display("FAIL reset_start_ignored: got busy=%b addr=%0d expected busy=0 addr=0", busy, inputSRAM_Addr);
    end
  endtask

  task automatic test_basic();
    int lat, max_a, dones;
    logic busy0, err0;
    logic [127:0] exp_d [3];
    exp_d[0] = 128'h030201;
    exp_d[1] = 128'h060504;
    exp_d[2] = 128'h090807;
    load_image(3, 0, 0);
    run_image(1'b0, lat, max_a, dones, busy0, err0);
    check_success("basic_n3", 3, 0, 0, lat, dones, busy0);
    checks++;
    if ((w_addr.size() != 3) || (w_addr[0] !== 13'd0) || (w_data[0] !== exp_d[0]) ||
        (w_addr[1] !== 13'd2) || (w_data[1] !== exp_d[1]) ||
        (w_addr[2] !== 13'd4) || (w_data[2] !== exp_d[2])) begin
      errors++;
      $display("FAIL basic_hand_words: got %0d writes, first data %h expected 3 writes at 0/2/4",
               w_addr.size(), (w_data.size() > 0) ? w_data[0] : 128'h0);
    end
    checks++;
    if (max_a !== 10) begin errors++; $display("FAIL basic_last_addr: got %0d expected 10", max_a); end
  endtask

  task automatic test_wide_rows();
    int lat, max_a, dones;
    logic busy0, err0;
    load_image(17, 16, 1);
    run_image(1'b0, lat, max_a, dones, busy0, err0);
    check_success("wide_n17", 17, 16, 1, lat, dones, busy0);
    checks++;
    if ((w_addr.size() < 2) || (w_addr[1] !== 13'd1) || (w_data[1] !== 128'h1) ||
        (w_data[0] !== {16{8'h01}})) begin
      errors++;
      $display("FAIL wide_odd_word: got %0d writes, word1 %h expected lane0=1 only", w_addr.size(),
               (w_data.size() > 1) ? w_data[1] : 128'h0);
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (loadChecksum !== 16'd289) begin errors++; $display("FAIL wide_checksum: got %0d expected 289", loadChecksum); end
`endif
  endtask

  task automatic test_boundary();
    int lat, max_a, dones;
    logic busy0, err0;
    load_image(31, 30, 2);
    run_image(1'b0, lat, max_a, dones, busy0, err0);
    check_success("bound_n31", 31, 30, 2, lat, dones, busy0);
    checks++;
    if (max_a !== 962) begin errors++; $display("FAIL bound_last_addr: got %0d expected 962", max_a); end
    load_image(32, 0, 2);
    run_image(1'b0, lat, max_a, dones, busy0, err0);
    check_error_run("bound_n32", lat, dones);
  endtask

  task automatic test_hdr_errors();
    int lat, max_a, dones;
    logic busy0, err0;
    load_image(0, 0, 0);
    run_image(1'b0, lat, max_a, dones, busy0, err0);
    check_error_run("err_n0", lat, dones);
    load_image(4, 4, 0);
    run_image(1'b0, lat, max_a, dones, busy0, err0);
    check_error_run("err_src4", lat, dones);
  endtask

  task automatic test_reset_mid_load();
    int lat, max_a, dones, we_seen;
    logic busy0, err0;
    we_seen = 0;
    load_image(10, 3, 2);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (43) @(negedge clock);
    checks++;
    if ((busy !== 1'b1) || (inputSRAM_Addr !== 10'd42)) begin
      errors++;
      $display("FAIL midload_progress: got busy=%b addr=%0d expected busy=1 addr=42", busy, inputSRAM_Addr);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL midload_reset_outputs: got %h expected 0", all_outs); end
    repeat (3) begin
      @(negedge clock);
      if (graph_WE) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin errors++; $display("FAIL midload_we_in_reset: got %0d expected 0", we_seen); end
    reset = 1'b1;
    @(negedge clock);
    run_image(1'b0, lat, max_a, dones, busy0, err0);
    check_success("midload_restart", 10, 3, 2, lat, dones, busy0);
  endtask

  task automatic test_back_to_back();
    int lat, max_a, dones;
    logic busy0, err0;
    load_image(0, 0, 0);
    run_image(1'b0, lat, max_a, dones, busy0, err0);
    check_error_run("b2b_err", lat, dones);
    load_image(3, 2, 0);
    run_image(1'b1, lat, max_a, dones, busy0, err0);
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL b2b_error_clear: got %b expected 0", err0); end
    check_success("b2b_spam", 3, 2, 0, lat, dones, busy0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_wide_rows();
    test_boundary();
    test_hdr_errors();
    test_reset_mid_load();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
